cordic_sweep_ctrl: RTL and testbench

Programmable frequency-sweep sequencer that drives the phase_inc input of the CORDIC NCO stage (phase accumulator, CORDIC, DAC scaling).
- Steps phase_inc from a start value to a stop value in fixed increments, holding each value for a programmable dwell.
- Configuration comes from LiteX CSRs and is shadowed at sweep start, so CSR writes during a sweep have no effect until the next start.

---
 rtl/cordic_sweep_pkg.sv | 23 ++
 rtl/sweep_next_inc.sv | 51 +++++
 rtl/cordic_sweep_ctrl.sv | 160 ++++++++++++++++
 tb/tb_cordic_sweep_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_sweep_pkg.sv
// ============================================================================
// Module      : cordic_sweep_pkg
// Description : Shared constants for the CORDIC NCO frequency-sweep sequencer.
//               Holds the FSM state encoding and the default widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cordic_sweep_pkg;

  // Default phase-increment width; must track the NCO phase accumulator
  localparam int PW_DEF = 19;
  // Default dwell counter width
  localparam int DW_DEF = 16;

  // Sequencer state encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DWELL = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/sweep_next_inc.sv
// ============================================================================
// Module      : sweep_next_inc
// Description : Combinational next-value generator for the frequency sweep.
//               Moves cur by step toward target, clamping so target is
//               emitted exactly and never overshot (including wrap-around).
// Ports       : cur       - current phase increment
//               step      - unsigned step magnitude
//               target    - endpoint of the current sweep leg
//               dir_up    - 1 = ascending leg, 0 = descending leg
//               nxt       - clamped next phase increment
//               at_target - cur already equals target
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sweep_next_inc
  import cordic_sweep_pkg::*;
#(
  parameter int PW = PW_DEF
) (
  input  logic [PW-1:0] cur,
  input  logic [PW-1:0] step,
  input  logic [PW-1:0] target,
  input  logic          dir_up,
  output logic [PW-1:0] nxt,
  output logic          at_target
);

  // One extra bit so carry-out / borrow are visible and force the clamp
  logic [PW:0] w_sum;
  logic [PW:0] w_diff;

  assign w_sum  = {1'b0, cur} + {1'b0, step};
  assign w_diff = {1'b0, cur} - {1'b0, step};

  always_comb begin
    nxt = target;
    if (dir_up) begin
      if (!w_sum[PW] && (w_sum[PW-1:0] <= target))
        nxt = w_sum[PW-1:0];
    end else begin
      if (!w_diff[PW] && (w_diff[PW-1:0] >= target))
        nxt = w_diff[PW-1:0];
    end
  end

  assign at_target = (cur == target);

endmodule

`default_nettype wire

// File: rtl/cordic_sweep_ctrl.sv
// ============================================================================
// Module      : cordic_sweep_ctrl
// Description : Programmable frequency-sweep sequencer driving phase_inc of
//               the CORDIC NCO. Steps from a start to a stop increment,
//               holding each value cfg_dwell+1 cycles. Configuration is
//               shadowed when a sweep starts.
// Options     : CORDIC_SWEEP_TRIANGLE_EN - when defined, looping sweeps
//               bounce between the endpoints instead of restarting.
// Ports       : sys_clk, rst_n (async, active-low)
//               cfg_start_inc / cfg_stop_inc / cfg_step / cfg_dwell / cfg_loop
//               start, abort  - single-cycle control pulses
//               phase_inc     - registered increment to the NCO
//               busy          - sweep in progress
//               done          - one-cycle pulse at end of non-looping sweep
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_sweep_ctrl
  import cordic_sweep_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic [PW-1:0] cfg_start_inc,
  input  logic [PW-1:0] cfg_stop_inc,
  input  logic [PW-1:0] cfg_step,
  input  logic [DW-1:0] cfg_dwell,
  input  logic          cfg_loop,
  input  logic          start,
  input  logic          abort,
  output logic [PW-1:0] phase_inc,
  output logic          busy,
  output logic          done
);

  localparam logic [PW-1:0] c_step_one = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] c_cnt_one  = {{(DW-1){1'b0}}, 1'b1};

  logic [1:0]    r_state;
  logic [DW-1:0] r_cnt;
  logic [PW-1:0] r_start;
  logic [PW-1:0] r_stop;
  logic [PW-1:0] r_step;
  logic [DW-1:0] r_dwell;
  logic          r_loop;
  logic          r_dir_up;

  logic [PW-1:0] w_tgt;
  logic          w_dir;
  logic [PW-1:0] w_nxt;
  logic          w_at_tgt;

`ifdef CORDIC_SWEEP_TRIANGLE_EN
  // r_fwd = 1 on the start->stop leg, 0 on the return leg
  logic          r_fwd;
  logic [PW-1:0] w_turn_nxt;
  logic          w_turn_unused;

  assign w_tgt = r_fwd ? r_stop : r_start;
  assign w_dir = r_fwd ? r_dir_up : ~r_dir_up;

  // First value of the opposite leg, so each endpoint is emitted only once
  sweep_next_inc #(.PW(PW)) u_turn (
    .cur       (phase_inc),
    .step      (r_step),
    .target    (r_fwd ? r_start : r_stop),
    .dir_up    (~w_dir),
    .nxt       (w_turn_nxt),
    .at_target (w_turn_unused)
  );
`else
  assign w_tgt = r_stop;
  assign w_dir = r_dir_up;
`endif

  sweep_next_inc #(.PW(PW)) u_next (
    .cur       (phase_inc),
    .step      (r_step),
    .target    (w_tgt),
    .dir_up    (w_dir),
    .nxt       (w_nxt),
    .at_target (w_at_tgt)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_start   <= '0;
      r_stop    <= '0;
      r_step    <= '0;
      r_dwell   <= '0;
      r_loop    <= 1'b0;
      r_dir_up  <= 1'b0;
      phase_inc <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef CORDIC_SWEEP_TRIANGLE_EN
      r_fwd     <= 1'b0;
`endif
    end else if (abort) begin
      // phase_inc deliberately untouched: the NCO keeps its current frequency
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_start   <= cfg_start_inc;
            r_stop    <= cfg_stop_inc;
            // A zero step would never reach a distinct stop value
            r_step    <= (cfg_step == '0) ? c_step_one : cfg_step;
            r_dwell   <= cfg_dwell;
            r_loop    <= cfg_loop;
            r_dir_up  <= (cfg_start_inc <= cfg_stop_inc);
            phase_inc <= cfg_start_inc;
            r_cnt     <= cfg_dwell;
            busy      <= 1'b1;
            r_state   <= S_DWELL;
`ifdef CORDIC_SWEEP_TRIANGLE_EN
            r_fwd     <= 1'b1;
`endif
          end
        end
        S_DWELL: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_cnt_one;
          end else if (!w_at_tgt) begin
            phase_inc <= w_nxt;
            r_cnt     <= r_dwell;
          end else if (r_loop) begin
            r_cnt <= r_dwell;
`ifdef CORDIC_SWEEP_TRIANGLE_EN
            r_fwd     <= ~r_fwd;
            phase_inc <= w_turn_nxt;
`else
            phase_inc <= r_start;
`endif
          end else begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cordic_sweep_ctrl.sv
// ============================================================================
// Module      : tb_cordic_sweep_ctrl
// Description : Self-checking bench for cordic_sweep_ctrl. A value-list model
//               of the sweep predicts phase_inc/busy/done for every cycle
//               after a start edge; a compare process checks each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_sweep_ctrl;

  localparam int PW = 19;
  localparam int DW = 16;
`ifdef CORDIC_SWEEP_TRIANGLE_EN
  localparam bit TRI = 1'b1;
`else
  localparam bit TRI = 1'b0;
`endif

  logic          sys_clk = 1'b0;
  logic          rst_n   = 1'b0;
  logic [PW-1:0] cfg_start_inc = '0;
  logic [PW-1:0] cfg_stop_inc  = '0;
  logic [PW-1:0] cfg_step      = '0;
  logic [DW-1:0] cfg_dwell     = '0;
  logic          cfg_loop      = 1'b0;
  logic          start         = 1'b0;
  logic          abort         = 1'b0;
  logic [PW-1:0] phase_inc;
  logic          busy;
  logic          done;

  cordic_sweep_ctrl #(.PW(PW), .DW(DW)) dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .cfg_start_inc (cfg_start_inc),
    .cfg_stop_inc  (cfg_stop_inc),
    .cfg_step      (cfg_step),
    .cfg_dwell     (cfg_dwell),
    .cfg_loop      (cfg_loop),
    .start         (start),
    .abort         (abort),
    .phase_inc     (phase_inc),
    .busy          (busy),
    .done          (done)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;

  // Expected per-cycle outputs, consumed one entry per falling edge
  int q_pi[$];
  bit q_busy[$];
  bit q_done[$];
  int cmp_idx = 0;

  // Model value lists: forward leg start->stop and return leg stop->start
  int m_fwd[$];
  int m_rev[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int   c_pi;
  bit   c_b;
  bit   c_d;
  always @(negedge sys_clk) begin
    if (q_pi.size() > 0) begin
      c_pi = q_pi.pop_front();
      c_b  = q_busy.pop_front();
      c_d  = q_done.pop_front();
      chk($sformatf("phase_inc[%0d]", cmp_idx), 32'(phase_inc), c_pi);
      chk($sformatf("busy[%0d]", cmp_idx), 32'(busy), 32'(c_b));
      chk($sformatf("done[%0d]", cmp_idx), 32'(done), 32'(c_d));
      cmp_idx++;
    end
  end

  function automatic int mnext(input int cur, input int step, input int stop, input bit up);
    int s;
    s = (step == 0) ? 1 : step;
    if (up) return (cur + s > stop) ? stop : cur + s;
    else    return (cur - s < stop) ? stop : cur - s;
  endfunction

  function automatic void build(input int s, input int p, input int st);
    int v;
    m_fwd = {};
    m_rev = {};
    v = s;
    m_fwd.push_back(v);
    while (v != p) begin
      v = mnext(v, st, p, s <= p);
      m_fwd.push_back(v);
    end
    v = p;
    m_rev.push_back(v);
    while (v != s) begin
      v = mnext(v, st, s, p <= s);
      m_rev.push_back(v);
    end
  endfunction

  // Run one sweep of n observed cycles. abort_at / restart_at give the cycle
  // index (after the start edge) during which abort / a stray start is driven.
  task automatic run(input int s, input int p, input int st, input int d, input bit lp,
                     input int n, input int abort_at, input int restart_at,
                     output int done_idx);
    int e_pi[$];
    bit e_b[$];
    bit e_d[$];
    int stream[$];
    build(s, p, st);
    if (!lp) begin
      stream = m_fwd;
    end else if (TRI) begin
      stream.push_back(m_fwd[0]);
      while (stream.size() * (d + 1) < n) begin
        if (m_fwd.size() == 1) stream.push_back(m_fwd[0]);
        for (int i = 1; i < m_fwd.size(); i++) stream.push_back(m_fwd[i]);
        for (int i = 1; i < m_rev.size(); i++) stream.push_back(m_rev[i]);
      end
    end else begin
      while (stream.size() * (d + 1) < n)
        foreach (m_fwd[i]) stream.push_back(m_fwd[i]);
    end
    foreach (stream[i])
      for (int r = 0; r <= d; r++) begin
        e_pi.push_back(stream[i]); e_b.push_back(1'b1); e_d.push_back(1'b0);
      end
    if (!lp) begin
      e_pi.push_back(p); e_b.push_back(1'b1); e_d.push_back(1'b0);
      e_pi.push_back(p); e_b.push_back(1'b0); e_d.push_back(1'b1);
    end
    while (e_pi.size() < n) begin
      e_pi.push_back(p); e_b.push_back(1'b0); e_d.push_back(1'b0);
    end
    while (e_pi.size() > n) begin
      void'(e_pi.pop_back()); void'(e_b.pop_back()); void'(e_d.pop_back());
    end
    if (abort_at >= 0)
      for (int i = abort_at + 1; i < n; i++) begin
        e_pi[i] = e_pi[abort_at]; e_b[i] = 1'b0; e_d[i] = 1'b0;
      end
    done_idx = -1;
    for (int i = n - 1; i >= 0; i--) if (e_d[i]) done_idx = i;

    @(negedge sys_clk);
    cfg_start_inc = PW'(s);
    cfg_stop_inc  = PW'(p);
    cfg_step      = PW'(st);
    cfg_dwell     = DW'(d);
    cfg_loop      = lp;
    start         = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    // Scramble the live configuration; the running sweep must ignore it
    cfg_start_inc = PW'($urandom);
    cfg_stop_inc  = PW'($urandom);
    cfg_step      = PW'($urandom);
    cfg_dwell     = DW'($urandom_range(0, 3));
    cfg_loop      = 1'($urandom);
    cmp_idx = 0;
    q_pi = e_pi; q_busy = e_b; q_done = e_d;
    for (int i = 0; i < n; i++) begin
      start = (i == restart_at) || (i == abort_at);
      abort = (i == abort_at);
      @(posedge sys_clk);
      #1;
    end
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 10 && q_pi.size() > 0; k++) @(posedge sys_clk);
    if (q_pi.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d entries left, expected 0", q_pi.size());
      q_pi = {}; q_busy = {}; q_done = {};
    end
  endtask

  int didx;
  int exp_up[4]    = '{1000, 1100, 1200, 1300};
  int exp_clamp[4] = '{1000, 1120, 1240, 1300};
  int exp_down[4]  = '{500, 400, 300, 200};
  int exp_ovf[3]   = '{32'h7FF00, 32'h7FF80, 32'h7FFFF};

  initial begin
    #2;
    chk("reset phase_inc", 32'(phase_inc), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    repeat (2) @(posedge sys_clk);
    #1 rst_n = 1'b1;

    // Up sweep; stray start while busy at cycle 2
    run(1000, 1300, 100, 3, 1'b0, 20, -1, 2, didx);
    foreach (exp_up[i]) chk($sformatf("model up[%0d]", i), 32'(m_fwd[i]), 32'(exp_up[i]));
    chk("done latency", 32'(didx), 17);
    chk("hold stop", 32'(phase_inc), 1300);
    chk("idle busy", 32'(busy), 0);

    // Clamped up sweep
    run(1000, 1300, 120, 3, 1'b0, 20, -1, -1, didx);
    foreach (exp_clamp[i]) chk($sformatf("model clamp[%0d]", i), 32'(m_fwd[i]), 32'(exp_clamp[i]));

    // Down sweep, stray start in the DONE cycle
    run(500, 200, 100, 0, 1'b0, 8, -1, 4, didx);
    foreach (exp_down[i]) chk($sformatf("model down[%0d]", i), 32'(m_fwd[i]), 32'(exp_down[i]));
    chk("down done latency", 32'(didx), 5);

    // Overflow clamp at top of range
    run(32'h7FF00, 32'h7FFFF, 32'h80, 1, 1'b0, 10, -1, -1, didx);
    chk("model ovf size", 32'(m_fwd.size()), 3);
    foreach (exp_ovf[i]) chk($sformatf("model ovf[%0d]", i), 32'(m_fwd[i]), 32'(exp_ovf[i]));

    // Abort in second cycle of 1100, with a simultaneous start
    run(1000, 1300, 100, 3, 1'b0, 14, 5, -1, didx);
    chk("abort hold", 32'(phase_inc), 1100);
    chk("abort busy", 32'(busy), 0);

    // step==0 behaves as step 1; start==stop holds one value
    run(10, 13, 0, 0, 1'b0, 8, -1, -1, didx);
    chk("step0 done latency", 32'(didx), 5);
    run(77, 77, 5, 2, 1'b0, 7, -1, -1, didx);
    chk("single done latency", 32'(didx), 4);

    // Looping sweep (sawtooth or triangle per build), ended with abort
    run(1000, 1300, 100, 3, 1'b1, 40, 36, -1, didx);
    chk("loop no done", 32'(didx), 32'hFFFF_FFFF);
    if (TRI) chk("model rev[1]", 32'(m_rev[1]), 1200);

    // Asynchronous reset mid-sweep
    @(negedge sys_clk);
    cfg_start_inc = PW'(1000); cfg_stop_inc = PW'(1300);
    cfg_step = PW'(100); cfg_dwell = DW'(3); cfg_loop = 1'b0;
    start = 1'b1;
    @(posedge sys_clk);
    #1 start = 1'b0;
    repeat (5) @(posedge sys_clk);
    #1;
    chk("pre-reset phase_inc", 32'(phase_inc), 1100);
    chk("pre-reset busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset phase_inc", 32'(phase_inc), 0);
    chk("async reset busy", 32'(busy), 0);
    @(negedge sys_clk);
    rst_n = 1'b1;

    // Recovery after reset
    run(500, 200, 100, 0, 1'b0, 8, -1, -1, didx);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
